// File: rtl/eth_txarb_pkg.sv
// Shared types for the N-channel Ethernet transmit arbiter: entry layout, FSM states.
package eth_txarb_pkg;

  localparam int ENTRY_W  = 74;
  localparam int LAST_BIT = 72;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

endpackage

// File: rtl/eth_txarb_rr_pick.sv
// Combinational grant picker: round-robin from ptr+1, or lowest index when prio is set.
// Zero latency; no backpressure, vld is low when nothing requests.
module rr_pick #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  input  logic           prio,
  output logic [IW-1:0]  idx,
  output logic           vld
);

  // Scan from the far end back toward the preferred start so the last hit wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    if (prio) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req[i]) begin
          idx = IW'(i);
          vld = 1'b1;
        end
      end
    end else begin
      for (int i = NCH; i >= 1; i--) begin
        if (req[(int'(ptr) + i) % NCH]) begin
          idx = IW'((int'(ptr) + i) % NCH);
          vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_txarb_n.sv
// Frame-granular N-channel transmit arbiter with length guard; pop at t, write at t+1.
// full blocks the pop in XFER; DRAIN discards the runaway tail regardless of full.
module eth_txarb_n
  import eth_txarb_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DW        = ENTRY_W,
  parameter int PRIO_MODE = 0,
  parameter int MAX_BEATS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    chan_en,
  output logic [NCH-1:0]    fifo_rd_en,
  input  logic [NCH*DW-1:0] fifo_dout,
  input  logic [NCH-1:0]    fifo_empty,
  output logic              wr_en,
  output logic [DW-1:0]     din,
  input  logic              full,
  output logic              trunc_pulse,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       trunc_cnt
);

  localparam int IW = $clog2(NCH);
  localparam int BW = $clog2(MAX_BEATS);

  state_t        state, state_nx;
  logic [IW-1:0] sel, rr_ptr, gnt_idx;
  logic          gnt_vld;
  logic [NCH-1:0] req;
  logic [BW-1:0] beat_cnt;
  logic [DW-1:0] head, head_out;
  logic          pop, head_last, at_limit, wr_nx, trunc_nx, done_nx;

  assign req       = ~fifo_empty & chan_en;
  assign head      = fifo_dout[int'(sel) * DW +: DW];
  assign head_last = head[LAST_BIT];
  assign at_limit  = (beat_cnt == BW'(MAX_BEATS - 1));

  rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .prio (PRIO_MODE != 0),
    .idx  (gnt_idx),
    .vld  (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    wr_nx    = 1'b0;
    trunc_nx = 1'b0;
    done_nx  = 1'b0;
    head_out = head;
    unique case (state)
      IDLE: if (gnt_vld) state_nx = XFER;
      XFER: begin
        pop   = ~fifo_empty[sel] & ~full;
        wr_nx = pop;
        if (pop && head_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (pop && at_limit) begin
          state_nx           = DRAIN;
          done_nx            = 1'b1;
          trunc_nx           = 1'b1;
          head_out[LAST_BIT] = 1'b1;
        end
      end
      DRAIN: begin
        pop = ~fifo_empty[sel];
        if (pop && head_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // A reset cycle must not consume a source entry.
    if (rst) pop = 1'b0;
    fifo_rd_en      = '0;
    fifo_rd_en[sel] = pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel         <= '0;
      rr_ptr      <= IW'(NCH - 1);
      beat_cnt    <= '0;
      wr_en       <= 1'b0;
      din         <= '0;
      trunc_pulse <= 1'b0;
      frame_cnt   <= '0;
      trunc_cnt   <= '0;
    end else begin
      wr_en       <= wr_nx;
      trunc_pulse <= trunc_nx;
      if (wr_nx) din <= head_out;
      if (state == IDLE && gnt_vld) begin
        sel      <= gnt_idx;
        beat_cnt <= '0;
        if (PRIO_MODE == 0) rr_ptr <= gnt_idx;
      end
      if (state == XFER && pop) beat_cnt <= beat_cnt + 1'b1;
      if (done_nx) frame_cnt <= frame_cnt + 1'b1;
      if (trunc_nx && trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_txarb_n.sv
// Directed bench for eth_txarb_n: RR instance (MAX_BEATS=4) and fixed-priority instance.
module tb_eth_txarb_n;
  import eth_txarb_pkg::*;

  localparam int NCH  = 4;
  localparam int DW   = ENTRY_W;
  localparam int MB_A = 4;
  localparam int MB_B = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NCH-1:0]      chan_en    [2];
  logic [NCH-1:0]      rd_en      [2];
  logic [NCH*DW-1:0]   dout       [2];
  logic [NCH-1:0]      empty      [2];
  logic                wr_en      [2];
  logic [DW-1:0]       din        [2];
  logic                full       [2];
  logic                tpulse     [2];
  logic [31:0]         fcnt       [2];
  logic [15:0]         tcnt       [2];

  logic tog = 1'b0;
  logic tgl = 1'b0;
  assign full[0] = tog & tgl;
  assign full[1] = 1'b0;

  eth_txarb_n #(.NCH(NCH), .DW(DW), .PRIO_MODE(0), .MAX_BEATS(MB_A)) dut_a (
    .clk(clk), .rst(rst), .chan_en(chan_en[0]), .fifo_rd_en(rd_en[0]),
    .fifo_dout(dout[0]), .fifo_empty(empty[0]), .wr_en(wr_en[0]), .din(din[0]),
    .full(full[0]), .trunc_pulse(tpulse[0]), .frame_cnt(fcnt[0]), .trunc_cnt(tcnt[0])
  );

  eth_txarb_n #(.NCH(NCH), .DW(DW), .PRIO_MODE(1), .MAX_BEATS(MB_B)) dut_b (
    .clk(clk), .rst(rst), .chan_en(chan_en[1]), .fifo_rd_en(rd_en[1]),
    .fifo_dout(dout[1]), .fifo_empty(empty[1]), .wr_en(wr_en[1]), .din(din[1]),
    .full(full[1]), .trunc_pulse(tpulse[1]), .frame_cnt(fcnt[1]), .trunc_cnt(tcnt[1])
  );

  // FWFT source FIFO models
  logic [DW-1:0] mem [2][NCH][64];
  int wp [2][NCH] = '{default: 0};
  int rp [2][NCH] = '{default: 0};

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      dout[d]  = '0;
      empty[d] = '0;
      for (int c = 0; c < NCH; c++) begin
        empty[d][c]          = (wp[d][c] == rp[d][c]);
        dout[d][c*DW +: DW]  = mem[d][c][rp[d][c]];
      end
    end
  end

  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++)
        if (rd_en[d][c] && !empty[d][c]) rp[d][c] <= (rp[d][c] + 1) % 64;

  always begin
    @(posedge clk);
    #2;
    tgl = ~tgl;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] expq0 [$];
  logic [DW-1:0] expq1 [$];
  int nwr [2] = '{0, 0};
  int ntp [2] = '{0, 0};
  int first_wr [2] = '{0, 0};
  int last_wr [2] = '{0, 0};
  logic full_prev [2] = '{1'b0, 1'b0};
  logic [DW-1:0] mon_e;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int d, input int ch, input int fr, input int b, input bit last);
    entry_t e;
    e.data = {8'(d), 8'(ch), 16'(fr), 32'(b)};
    e.keep = 8'(8'hF0 ^ b);
    e.user = ch[0];
    e.last = last;
    return e;
  endfunction

  // Loads a frame into a source; queues what the DUT should write (truncated at mb beats).
  task automatic push_frame(input int d, input int ch, input int fr, input int nb, input int mb, input bit expect_it);
    logic [DW-1:0] x;
    for (int b = 0; b < nb; b++) begin
      x = mk(d, ch, fr, b, (b == nb - 1));
      mem[d][ch][wp[d][ch]] = x;
      wp[d][ch] = (wp[d][ch] + 1) % 64;
      if (expect_it && b < mb) begin
        if (b == mb - 1) x[LAST_BIT] = 1'b1;
        if (d == 0) expq0.push_back(x);
        else        expq1.push_back(x);
      end
    end
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n;
    n = 0;
    while (((d == 0) ? expq0.size() : expq1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < budget, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_en[d]) begin
        mon_e = 'x;
        if (d == 0 && expq0.size() > 0) mon_e = expq0.pop_front();
        if (d == 1 && expq1.size() > 0) mon_e = expq1.pop_front();
        chk((d == 0) ? "A_din" : "B_din", din[d], mon_e);
        chk("wr_after_full", full_prev[d], 1'b0);
        if (nwr[d] == 0) first_wr[d] = cyc;
        last_wr[d] = cyc;
        nwr[d]++;
      end
      if (tpulse[d]) begin
        ntp[d]++;
        chk("trunc_on_last", {wr_en[d], din[d][LAST_BIT]}, 2'b11);
      end
      if (rd_en[d] != '0) begin
        chk("rd_onehot", $onehot(rd_en[d]), 1'b1);
        chk("pop_nonempty", |(rd_en[d] & empty[d]), 1'b0);
      end
      full_prev[d] = full[d];
    end
  end

  initial begin
    int n;
    rst        = 1'b1;
    chan_en[0] = 4'hF;
    chan_en[1] = 4'hF;
    repeat (3) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk("rst_rd_en", rd_en[d], 0);
      chk("rst_wr_en", wr_en[d], 0);
      chk("rst_din", din[d], 0);
      chk("rst_trunc_pulse", tpulse[d], 0);
      chk("rst_frame_cnt", fcnt[d], 0);
      chk("rst_trunc_cnt", tcnt[d], 0);
    end

    // A: four 3-beat frames, expected RR order 0,1,2,3
    for (int c = 0; c < NCH; c++) push_frame(0, c, c, 3, MB_A, 1'b1);
    // B: ch0 holds three frames, ch2 one; ch2 must wait for all of ch0
    push_frame(1, 0, 0, 2, MB_B, 1'b1);
    push_frame(1, 0, 1, 2, MB_B, 1'b1);
    push_frame(1, 0, 2, 2, MB_B, 1'b1);
    push_frame(1, 2, 3, 2, MB_B, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    wait_idle(0, 100);
    wait_idle(1, 100);
    chk("A_frame_cnt_4", fcnt[0], 4);
    chk("A_beats_12", nwr[0], 12);
    chk("A_span_cycles", last_wr[0] - first_wr[0], 14);
    chk("B_frame_cnt_4", fcnt[1], 4);
    chk("B_beats_8", nwr[1], 8);

    // channel enable: ch2 masked, then re-enabled alongside a new ch0 frame
    @(negedge clk);
    chan_en[0] = 4'b1011;
    push_frame(0, 1, 10, 2, MB_A, 1'b1);
    push_frame(0, 3, 12, 2, MB_A, 1'b1);
    push_frame(0, 2, 11, 2, MB_A, 1'b0);
    wait_idle(0, 100);
    chk("A_ch2_still_pending", empty[0][2], 1'b0);
    push_frame(0, 0, 13, 2, MB_A, 1'b1);
    for (int b = 0; b < 2; b++) expq0.push_back(mk(0, 2, 11, b, (b == 1)));
    chan_en[0] = 4'hF;
    wait_idle(0, 100);
    chk("A_frame_cnt_8", fcnt[0], 8);

    // truncation: 10-beat frame on ch1, then a ch2 frame must follow
    push_frame(0, 1, 20, 10, MB_A, 1'b1);
    push_frame(0, 2, 21, 1, MB_A, 1'b1);
    wait_idle(0, 100);
    chk("A_trunc_pulses", ntp[0], 1);
    chk("A_trunc_cnt", tcnt[0], 1);
    chk("A_ch1_drained", empty[0][1], 1'b1);
    chk("A_frame_cnt_10", fcnt[0], 10);

    // backpressure toggling every cycle
    tog = 1'b1;
    push_frame(0, 3, 30, 4, MB_A, 1'b1);
    push_frame(0, 0, 31, 3, MB_A, 1'b1);
    wait_idle(0, 200);
    tog = 1'b0;
    chk("A_frame_cnt_12", fcnt[0], 12);
    chk("A_trunc_cnt_hold", tcnt[0], 1);

    // reset mid-frame: one beat out, rest stays in the source
    push_frame(0, 1, 40, 4, MB_A, 1'b0);
    expq0.push_back(mk(0, 1, 40, 0, 1'b0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_en[0] && n < 20);
    chk("A_first_beat_timeout", n < 20, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rd_en", rd_en[0], 0);
    chk("mid_rst_wr_en", wr_en[0], 0);
    chk("mid_rst_din", din[0], 0);
    chk("mid_rst_trunc_pulse", tpulse[0], 0);
    chk("mid_rst_frame_cnt", fcnt[0], 0);
    chk("mid_rst_trunc_cnt", tcnt[0], 0);
    chk("mid_rst_src_left", (wp[0][1] - rp[0][1] + 64) % 64, 3);
    rst = 1'b0;
    for (int b = 1; b < 4; b++) expq0.push_back(mk(0, 1, 40, b, (b == 3)));
    wait_idle(0, 100);
    chk("A_frame_cnt_after_rst", fcnt[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
